// File: rtl/systolic_drain.sv
// rtl/systolic_drain.sv - drains per-row systolic result beats into N1 output banks
// Each row walks its own patch/beat counters; beats within a patch land at descending addresses.
module systolic_drain #(
  parameter int D_W_ACC = 16,
  parameter int N1 = 4,
  parameter int N2 = 4,
  parameter int M = 8,
  localparam int PATCHES = (M * M) / (N1 * N2),
  localparam int DEPTH = (M * M) / N1,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int BW = (N2 > 1) ? $clog2(N2) : 1,
  localparam int PW = (PATCHES > 1) ? $clog2(PATCHES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N1-1:0]      valid_D,
  input  logic [D_W_ACC-1:0] D [N1],
  output logic [N1-1:0]      wr_en,
  output logic [AW-1:0]      wr_addr [N1],
  output logic [D_W_ACC-1:0] wr_data [N1],
  output logic               done,
  output logic               overflow
);

  typedef enum logic {FILL, FULL} row_state_t;

  row_state_t    state      [N1];
  row_state_t    state_next [N1];
  logic [BW-1:0] beat_cnt   [N1];
  logic [BW-1:0] beat_next  [N1];
  logic [PW-1:0] patch_cnt  [N1];
  logic [PW-1:0] patch_next [N1];
  logic [AW-1:0] addr_calc  [N1];
  logic [N1-1:0] accept;
  logic [N1-1:0] reject;
  logic [N1-1:0] full;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N1; i++) begin
        state[i]     <= FILL;
        beat_cnt[i]  <= '0;
        patch_cnt[i] <= '0;
        wr_addr[i]   <= '0;
        wr_data[i]   <= '0;
      end
      wr_en    <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      for (int i = 0; i < N1; i++) begin
        state[i]     <= state_next[i];
        beat_cnt[i]  <= beat_next[i];
        patch_cnt[i] <= patch_next[i];
        if (accept[i]) begin
          wr_addr[i] <= addr_calc[i];
          wr_data[i] <= D[i];
        end
      end
      wr_en <= accept;
      // full[] is already registered, so done trails the last write strobe by one cycle
      done     <= start ? 1'b0 : &full;
      overflow <= start ? 1'b0 : (overflow | (|reject));
    end
  end

  always_comb begin
    accept = '0;
    reject = '0;
    full   = '0;
    for (int i = 0; i < N1; i++) begin
      state_next[i] = state[i];
      beat_next[i]  = beat_cnt[i];
      patch_next[i] = patch_cnt[i];
      full[i]       = (state[i] == FULL);
      // beat k of a patch carries column N2-1-k
      addr_calc[i]  = AW'(int'(patch_cnt[i]) * N2 + (N2 - 1 - int'(beat_cnt[i])));
      if (start) begin
        state_next[i] = FILL;
        beat_next[i]  = '0;
        patch_next[i] = '0;
      end else if (valid_D[i]) begin
        case (state[i])
          FILL: begin
            accept[i] = 1'b1;
            if (beat_cnt[i] == BW'(N2 - 1)) begin
              beat_next[i] = '0;
              if (patch_cnt[i] == PW'(PATCHES - 1)) begin
                state_next[i] = FULL;
              end else begin
                patch_next[i] = patch_cnt[i] + 1'b1;
              end
            end else begin
              beat_next[i] = beat_cnt[i] + 1'b1;
            end
          end
          FULL: begin
            reject[i] = 1'b1;
          end
          default: begin
            state_next[i] = FILL;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_systolic_drain.sv
// tb/tb_systolic_drain.sv - randomized bench for systolic_drain against a beat-count model
module tb_systolic_drain;
  localparam int D_W_ACC = 16;
  localparam int N1 = 4;
  localparam int N2 = 4;
  localparam int M = 8;
  localparam int DEPTH = (M * M) / N1;
  localparam int AW = $clog2(DEPTH);

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [N1-1:0]      valid_D;
  logic [D_W_ACC-1:0] D [N1];
  logic [N1-1:0]      wr_en;
  logic [AW-1:0]      wr_addr [N1];
  logic [D_W_ACC-1:0] wr_data [N1];
  logic               done;
  logic               overflow;

  int checks = 0;
  int errors = 0;

  int            cnt [N1];
  logic [N1-1:0] e_en;
  int            e_addr [N1];
  int            e_data [N1];
  logic          e_done;
  logic          e_ovf;
  int            hits [N1][DEPTH];

  systolic_drain #(.D_W_ACC(D_W_ACC), .N1(N1), .N2(N2), .M(M)) dut (
    .clk(clk), .rst(rst), .start(start), .valid_D(valid_D), .D(D),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: a row has simply accepted cnt beats; beat n lands at patch*N2 + (N2-1-col)
  task automatic step();
    logic all_full;
    all_full = 1'b1;
    for (int i = 0; i < N1; i++) if (cnt[i] < DEPTH) all_full = 1'b0;
    if (rst) begin
      for (int i = 0; i < N1; i++) begin
        cnt[i] = 0; e_addr[i] = 0; e_data[i] = 0;
      end
      e_en = '0; e_done = 1'b0; e_ovf = 1'b0;
    end else if (start) begin
      for (int i = 0; i < N1; i++) cnt[i] = 0;
      e_en = '0; e_done = 1'b0; e_ovf = 1'b0;
    end else begin
      e_done = all_full;
      for (int i = 0; i < N1; i++) begin
        e_en[i] = 1'b0;
        if (valid_D[i]) begin
          if (cnt[i] < DEPTH) begin
            e_en[i]   = 1'b1;
            e_addr[i] = (cnt[i] / N2) * N2 + (N2 - 1 - (cnt[i] % N2));
            e_data[i] = int'(D[i]);
            cnt[i]++;
          end else begin
            e_ovf = 1'b1;
          end
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("wr_en", 32'(wr_en), 32'(e_en));
    for (int i = 0; i < N1; i++) begin
      check($sformatf("wr_addr[%0d]", i), 32'(wr_addr[i]), 32'(e_addr[i]));
      check($sformatf("wr_data[%0d]", i), 32'(wr_data[i]), 32'(e_data[i]));
      if (wr_en[i]) hits[i][wr_addr[i]]++;
    end
    check("done", 32'(done), 32'(e_done));
    check("overflow", 32'(overflow), 32'(e_ovf));
  endtask

  task automatic idle(input int n);
    rst = 1'b0; start = 1'b0; valid_D = '0;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic pulse_start(input logic [N1-1:0] v);
    start = 1'b1; valid_D = v;
    for (int i = 0; i < N1; i++) D[i] = D_W_ACC'($urandom);
    step();
    start = 1'b0; valid_D = '0;
  endtask

  task automatic beats_row0(input int n);
    for (int k = 0; k < n; k++) begin
      valid_D = 4'b0001; D[0] = D_W_ACC'($urandom);
      step();
    end
    valid_D = '0;
  endtask

  initial begin
    int sent [N1];
    int t;
    logic pending;
    for (int i = 0; i < N1; i++) begin
      cnt[i] = 0; e_addr[i] = 0; e_data[i] = 0; D[i] = '0;
      for (int a = 0; a < DEPTH; a++) hits[i][a] = 0;
    end
    e_en = '0; e_done = 1'b0; e_ovf = 1'b0;
    rst = 1'b1; start = 1'b0; valid_D = '0;
    @(negedge clk);

    // Reset with random activity on the inputs
    for (int k = 0; k < 2; k++) begin
      rst = 1'b1; start = ($urandom_range(0, 1) == 1);
      valid_D = N1'($urandom);
      for (int i = 0; i < N1; i++) D[i] = D_W_ACC'($urandom);
      step();
    end
    rst = 1'b0;
    idle(1);

    // Single patch on row 0: addresses 3,2,1,0
    for (int k = 0; k < 4; k++) begin
      valid_D = 4'b0001; D[0] = D_W_ACC'(10 + k);
      step();
      check("single_addr", 32'(wr_addr[0]), 32'(3 - k));
      check("single_data", 32'(wr_data[0]), 32'(10 + k));
    end
    idle(1);

    // Full matrix, skewed rows with random gaps
    pulse_start('0);
    for (int i = 0; i < N1; i++) begin
      sent[i] = 0;
      for (int a = 0; a < DEPTH; a++) hits[i][a] = 0;
    end
    t = 0;
    pending = 1'b1;
    while (pending && t < 300) begin
      for (int i = 0; i < N1; i++) begin
        valid_D[i] = (t >= i) && (sent[i] < DEPTH) && ($urandom_range(0, 3) != 0);
        D[i] = D_W_ACC'($urandom);
        if (valid_D[i]) sent[i]++;
      end
      step();
      t++;
      pending = 1'b0;
      for (int i = 0; i < N1; i++) if (sent[i] < DEPTH) pending = 1'b1;
    end
    check("matrix_in_budget", 32'(t < 300), 32'd1);
    idle(2);
    check("matrix_done", 32'(done), 32'd1);
    for (int i = 0; i < N1; i++)
      for (int a = 0; a < DEPTH; a++)
        check($sformatf("bank%0d_addr%0d_writes", i, a), 32'(hits[i][a]), 32'd1);

    // Overflow after done
    valid_D = 4'b0100; D[2] = D_W_ACC'($urandom);
    step();
    check("ovf_no_write", 32'(wr_en[2]), 32'd0);
    idle(3);
    check("ovf_sticky", 32'(overflow), 32'd1);
    pulse_start('0);
    check("start_clears_done", 32'(done), 32'd0);
    check("start_clears_ovf", 32'(overflow), 32'd0);

    // Restart with a beat coinciding with start
    beats_row0(2);
    pulse_start(4'b0001);
    beats_row0(1);
    check("restart_addr", 32'(wr_addr[0]), 32'd3);
    idle(1);

    // Mid-run reset during patch 2
    pulse_start('0);
    beats_row0(9);
    rst = 1'b1; valid_D = 4'b0001; D[0] = D_W_ACC'($urandom);
    step();
    rst = 1'b0; valid_D = '0;
    check("rst_wr_en", 32'(wr_en), 32'd0);
    idle(1);
    beats_row0(1);
    check("post_rst_addr", 32'(wr_addr[0]), 32'd3);

    // Random traffic with occasional restarts
    for (int k = 0; k < 600; k++) begin
      rst = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 99) == 0);
      valid_D = N1'($urandom);
      for (int i = 0; i < N1; i++) D[i] = D_W_ACC'($urandom);
      step();
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
